// File: rtl/sdram_burst_scheduler.sv
// Arbitrates the SDRAM command engine between one write FIFO, two read FIFOs and auto-refresh.
// Optional macro SCHED_RR_EN selects round-robin between the read ports (default: rd1 > rd2).
module sdram_burst_scheduler #(
  parameter int ADDR_W         = 23,
  parameter int LEN_W          = 9,
  parameter int LVL_W          = 10,
  parameter int FIFO_DEPTH     = 512,
  parameter int REFRESH_PERIOD = 1700
) (
  input  logic              clk,
  input  logic              areset,
  input  logic [LVL_W-1:0]  wr_level,
  input  logic [LVL_W-1:0]  rd1_level,
  input  logic [LVL_W-1:0]  rd2_level,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [ADDR_W-1:0] wr_max,
  input  logic [ADDR_W-1:0] rd1_base,
  input  logic [ADDR_W-1:0] rd1_max,
  input  logic [ADDR_W-1:0] rd2_base,
  input  logic [ADDR_W-1:0] rd2_max,
  input  logic [2:0]        load,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_op,
  output logic [1:0]        cmd_port,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_done,
  output logic              busy,
  output logic              refresh_overrun
);

  localparam int SUM_W = LVL_W + 1;
  localparam int CNT_W = $clog2(REFRESH_PERIOD);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_REF  = 2'b11;

  localparam logic [1:0] PORT_WR  = 2'd0;
  localparam logic [1:0] PORT_RD1 = 2'd1;
  localparam logic [1:0] PORT_RD2 = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [1:0]          port_q, port_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd1_ptr_q, rd1_ptr_d;
  logic [ADDR_W-1:0]   rd2_ptr_q, rd2_ptr_d;
  logic [CNT_W-1:0]    ref_cnt_q, ref_cnt_d;
  logic                ref_pend_q, ref_pend_d;
  logic                overrun_q, overrun_d;
`ifdef SCHED_RR_EN
  logic                rr_last_q, rr_last_d;
`endif

  logic [SUM_W-1:0] len_ext;
  logic             wr_req, rd1_req, rd2_req, pick_rd2;
  logic             ref_term, ref_accept, advance_en;

  // Levels are widened by one bit so level + burst_len cannot overflow.
  assign len_ext  = SUM_W'(burst_len);
  assign wr_req   = SUM_W'(wr_level) >= len_ext;
  assign rd1_req  = (SUM_W'(rd1_level) + len_ext) <= SUM_W'(FIFO_DEPTH);
  assign rd2_req  = (SUM_W'(rd2_level) + len_ext) <= SUM_W'(FIFO_DEPTH);

`ifdef SCHED_RR_EN
  // rr_last_q = 1 means rd2 was granted last, so rd1 wins a tie.
  assign pick_rd2 = rd2_req && (!rd1_req || !rr_last_q);
`else
  assign pick_rd2 = rd2_req && !rd1_req;
`endif

  assign ref_term   = ref_cnt_q == CNT_W'(REFRESH_PERIOD - 1);
  assign ref_accept = (state_q == ISSUE) && cmd_ready && (op_q == OP_REF);
  assign advance_en = (state_q == BUSY) && cmd_done && (op_q != OP_REF);

  function automatic logic [ADDR_W-1:0] next_ptr(
    input logic [ADDR_W-1:0] ptr,
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] max,
    input logic [LEN_W-1:0]  len
  );
    logic [ADDR_W+1:0] nxt;
    nxt = (ADDR_W+2)'(ptr) + (ADDR_W+2)'(len);
    if (nxt + (ADDR_W+2)'(len) > (ADDR_W+2)'(max)) next_ptr = base;
    else                                           next_ptr = nxt[ADDR_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    port_d  = port_q;
    addr_d  = addr_q;
    len_d   = len_q;
`ifdef SCHED_RR_EN
    rr_last_d = rr_last_q;
`endif
    case (state_q)
      IDLE: begin
        if (ref_pend_q) begin
          state_d = ISSUE;
          op_d    = OP_REF;
          port_d  = PORT_WR;
          addr_d  = '0;
          len_d   = '0;
        end else if (wr_req) begin
          state_d = ISSUE;
          op_d    = OP_WR;
          port_d  = PORT_WR;
          addr_d  = wr_ptr_q;
          len_d   = burst_len;
        end else if (rd1_req || rd2_req) begin
          state_d = ISSUE;
          op_d    = OP_RD;
          len_d   = burst_len;
          if (pick_rd2) begin
            port_d = PORT_RD2;
            addr_d = rd2_ptr_q;
          end else begin
            port_d = PORT_RD1;
            addr_d = rd1_ptr_q;
          end
`ifdef SCHED_RR_EN
          rr_last_d = pick_rd2;
`endif
        end
      end
      ISSUE: if (cmd_ready) state_d = BUSY;
      BUSY: begin
        if (cmd_done) begin
          state_d = IDLE;
          op_d    = OP_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Load strobes are applied after the advance so a same-cycle reload wins.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd1_ptr_d = rd1_ptr_q;
    rd2_ptr_d = rd2_ptr_q;
    if (advance_en) begin
      case (port_q)
        PORT_WR:  wr_ptr_d  = next_ptr(wr_ptr_q,  wr_base,  wr_max,  burst_len);
        PORT_RD1: rd1_ptr_d = next_ptr(rd1_ptr_q, rd1_base, rd1_max, burst_len);
        PORT_RD2: rd2_ptr_d = next_ptr(rd2_ptr_q, rd2_base, rd2_max, burst_len);
        default: ;
      endcase
    end
    if (load[0]) wr_ptr_d  = wr_base;
    if (load[1]) rd1_ptr_d = rd1_base;
    if (load[2]) rd2_ptr_d = rd2_base;
  end

  always_comb begin
    ref_cnt_d  = ref_term ? '0 : ref_cnt_q + CNT_W'(1);
    ref_pend_d = ref_pend_q;
    if (ref_accept) ref_pend_d = 1'b0;
    if (ref_term)   ref_pend_d = 1'b1;
    overrun_d  = overrun_q | (ref_term & ref_pend_q);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      op_q       <= OP_NONE;
      port_q     <= PORT_WR;
      addr_q     <= '0;
      len_q      <= '0;
      wr_ptr_q   <= wr_base;
      rd1_ptr_q  <= rd1_base;
      rd2_ptr_q  <= rd2_base;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef SCHED_RR_EN
      rr_last_q  <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      port_q     <= port_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wr_ptr_q   <= wr_ptr_d;
      rd1_ptr_q  <= rd1_ptr_d;
      rd2_ptr_q  <= rd2_ptr_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      overrun_q  <= overrun_d;
`ifdef SCHED_RR_EN
      rr_last_q  <= rr_last_d;
`endif
    end
  end

  assign cmd_valid       = state_q == ISSUE;
  assign busy            = state_q != IDLE;
  assign cmd_op          = op_q;
  assign cmd_port        = port_q;
  assign cmd_addr        = addr_q;
  assign cmd_len         = len_q;
  assign refresh_overrun = overrun_q;

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Directed self-checking bench for sdram_burst_scheduler (refresh period shortened to 300).
module tb_sdram_burst_scheduler;

  localparam int ADDR_W = 23;
  localparam int LEN_W  = 9;
  localparam int LVL_W  = 10;
  localparam int DEPTH  = 512;
  localparam int RP     = 300;

  logic              clk = 1'b0;
  logic              areset;
  logic [LVL_W-1:0]  wr_level, rd1_level, rd2_level;
  logic [LEN_W-1:0]  burst_len;
  logic [ADDR_W-1:0] wr_base, wr_max, rd1_base, rd1_max, rd2_base, rd2_max;
  logic [2:0]        load;
  logic              cmd_valid, cmd_ready, cmd_done, busy, refresh_overrun;
  logic [1:0]        cmd_op, cmd_port;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  int checks = 0;
  int fails  = 0;

  sdram_burst_scheduler #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .LVL_W(LVL_W),
    .FIFO_DEPTH(DEPTH), .REFRESH_PERIOD(RP)
  ) dut (
    .clk(clk), .areset(areset),
    .wr_level(wr_level), .rd1_level(rd1_level), .rd2_level(rd2_level),
    .burst_len(burst_len),
    .wr_base(wr_base), .wr_max(wr_max),
    .rd1_base(rd1_base), .rd1_max(rd1_max),
    .rd2_base(rd2_base), .rd2_max(rd2_max),
    .load(load),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_port(cmd_port), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_done(cmd_done), .busy(busy), .refresh_overrun(refresh_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic end_test();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  endtask

  task automatic accept();
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
  endtask

  task automatic finish_cmd(input int n);
    repeat (n - 1) begin @(posedge clk); #1; end
    cmd_done = 1'b1;
    @(posedge clk); #1;
    cmd_done = 1'b0;
  endtask

  // Waits for the next offered command; optionally services refreshes transparently.
  task automatic next_cmd(input bit skip_ref, input string tag, output int n);
    int  waited;
    bit  got;
    got = 0;
    n   = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      waited = 0;
      while (!cmd_valid && waited < 1000) begin
        @(posedge clk); #1;
        waited++;
      end
      if (!cmd_valid) begin
        chk(tag, cmd_valid, 1);
        end_test();
      end
      if (skip_ref && cmd_op == 2'b11) begin
        accept();
        finish_cmd(1);
      end else begin
        got = 1;
        n   = waited;
      end
    end
  endtask

  int                n, cyc, seen;
  logic [ADDR_W-1:0] wr_exp;
  logic [1:0]        rr_port [4];
  logic [ADDR_W-1:0] rr_addr [4];

  initial begin
    areset    = 1'b1;
    wr_level  = '0;
    rd1_level = LVL_W'(DEPTH);
    rd2_level = LVL_W'(DEPTH);
    burst_len = 9'd128;
    wr_base   = '0;
    wr_max    = 23'd315392;
    rd1_base  = '0;
    rd1_max   = 23'h100000;
    rd2_base  = 23'h100000;
    rd2_max   = 23'h200000;
    load      = '0;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;

    #12;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_op", cmd_op, 0);
    chk("rst_port", cmd_port, 0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_len", cmd_len, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", refresh_overrun, 0);
    @(negedge clk);
    areset = 1'b0;

    // First refresh appears REFRESH_PERIOD+1 edges after reset release.
    cyc = 0;
    while (!cmd_valid && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ref_first_cycle", cyc, RP + 1);
    chk("ref_op", cmd_op, 3);
    chk("ref_port", cmd_port, 0);
    chk("ref_len", cmd_len, 0);
    chk("ref_busy", busy, 1);
    accept();
    chk("ref_valid_drop", cmd_valid, 0);
    chk("ref_busy_after", busy, 1);
    finish_cmd(3);
    chk("ref_idle", busy, 0);

    // Just below every request threshold: nothing may be offered.
    wr_level  = 10'd127;
    rd1_level = 10'd385;
    rd2_level = 10'd385;
    seen = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (cmd_valid) seen++;
    end
    chk("no_req_idle", seen, 0);

    // Write stream through the frame buffer wrap.
    wr_level  = 10'd128;
    rd1_level = LVL_W'(DEPTH);
    rd2_level = LVL_W'(DEPTH);
    wr_exp = '0;
    for (int i = 0; i < 2466; i++) begin
      next_cmd(1'b1, "wr_wait", n);
      if (i > 0) chk("wr_gap", n, 1);
      chk("wr_op", cmd_op, 1);
      chk("wr_port", cmd_port, 0);
      chk("wr_addr", cmd_addr, wr_exp);
      chk("wr_len", cmd_len, 128);
      if (i == 2463) chk("wr_last_before_wrap", cmd_addr, 315264);
      if (i == 2464) chk("wr_wrapped", cmd_addr, 0);
      accept();
      finish_cmd(10);
      wr_exp = (wr_exp + 256 > 315392) ? '0 : wr_exp + 23'd128;
      if (i == 2465) wr_level = '0;
    end

    // Both read ports requesting continuously.
`ifdef SCHED_RR_EN
    rr_port = '{2'd1, 2'd2, 2'd1, 2'd2};
    rr_addr = '{23'd0, 23'h100000, 23'd128, 23'h100080};
`else
    rr_port = '{2'd1, 2'd1, 2'd1, 2'd1};
    rr_addr = '{23'd0, 23'd128, 23'd256, 23'd384};
`endif
    rd1_level = '0;
    rd2_level = '0;
    for (int i = 0; i < 4; i++) begin
      next_cmd(1'b1, "rd_wait", n);
      chk("rd_gap", n, 1);
      chk("rd_op", cmd_op, 2);
      chk("rd_port", cmd_port, rr_port[i]);
      chk("rd_addr", cmd_addr, rr_addr[i]);
      accept();
      if (i == 3) begin
        rd1_level = LVL_W'(DEPTH);
        rd2_level = LVL_W'(DEPTH);
      end
      finish_cmd(4);
    end

    // Reload rd1 to 8320, then reload again on the same cycle as its done.
    rd1_base = 23'd8320;
    load = 3'b010;
    @(posedge clk); #1;
    load = '0;
    rd1_base = 23'd1000;
    rd1_level = 10'd384;
    next_cmd(1'b1, "ld_wait", n);
    chk("ld_op", cmd_op, 2);
    chk("ld_port", cmd_port, 1);
    chk("ld_addr", cmd_addr, 8320);
    accept();
    chk("ld_addr_held", cmd_addr, 8320);
    repeat (3) begin @(posedge clk); #1; end
    cmd_done = 1'b1;
    load = 3'b010;
    @(posedge clk); #1;
    cmd_done = 1'b0;
    load = '0;
    next_cmd(1'b1, "ld2_wait", n);
    chk("ld2_port", cmd_port, 1);
    chk("ld2_addr", cmd_addr, 1000);
    accept();
    rd1_level = LVL_W'(DEPTH);
    finish_cmd(2);

    // Long busy: refresh overruns, then refresh beats WR which beats reads.
    chk("ovr_clear", refresh_overrun, 0);
    wr_level  = 10'd128;
    rd1_level = '0;
    next_cmd(1'b1, "pri_wr_wait", n);
    chk("pri_wr0_op", cmd_op, 1);
    chk("pri_wr0_addr", cmd_addr, wr_exp);
    accept();
    wr_exp = wr_exp + 23'd128;
    seen = 0;
    repeat (2 * RP + 20) begin
      @(posedge clk); #1;
      if (cmd_valid) seen++;
    end
    chk("busy_no_preempt", seen, 0);
    chk("ovr_set", refresh_overrun, 1);
    finish_cmd(1);
    next_cmd(1'b0, "pri_ref_wait", n);
    chk("pri_ref_gap", n, 1);
    chk("pri_ref_op", cmd_op, 3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", cmd_valid, 1);
      chk("stall_op", cmd_op, 3);
      chk("stall_port", cmd_port, 0);
      chk("stall_len", cmd_len, 0);
    end
    accept();
    finish_cmd(2);
    next_cmd(1'b1, "pri_wr_wait2", n);
    chk("pri_wr_op", cmd_op, 1);
    chk("pri_wr_addr", cmd_addr, wr_exp);
    accept();
    wr_exp = wr_exp + 23'd128;
    wr_level = '0;
    finish_cmd(2);
    next_cmd(1'b1, "pri_rd_wait", n);
    chk("pri_rd_op", cmd_op, 2);
    chk("pri_rd_port", cmd_port, 1);
    chk("pri_rd_addr", cmd_addr, 1128);
    accept();
    rd1_level = LVL_W'(DEPTH);
    finish_cmd(2);
    chk("ovr_sticky", refresh_overrun, 1);

    // Asynchronous reset while a command is offered.
    wr_base  = 23'd4096;
    wr_level = 10'd128;
    next_cmd(1'b1, "ar_wait", n);
    chk("ar_addr_before", cmd_addr, wr_exp);
    #3;
    areset = 1'b1;
    #1;
    chk("ar_valid", cmd_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_op", cmd_op, 0);
    chk("ar_addr", cmd_addr, 0);
    chk("ar_overrun", refresh_overrun, 0);
    @(negedge clk);
    areset = 1'b0;
    next_cmd(1'b1, "ar_wr_wait", n);
    chk("ar_wr_op", cmd_op, 1);
    chk("ar_wr_base", cmd_addr, 4096);
    accept();
    wr_level = '0;
    finish_cmd(2);

    end_test();
  end

endmodule
